uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter TICKS_PER_BIT, default 16: number of TICK pulses per serial bit; legal range 2..16.
REQ-002 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 TICK  input  1  16x-oversample strobe from the baud rate generator (CLK_OUT); one-CLK pulse.
REQ-005 BAUD_EN  output  1  enable to the baud rate generator; high while a frame is in progress.
REQ-006 REQ0, REQ1  input  1 each  transmit request from requester 0 / 1; level, held until granted.
REQ-007 DATA0, DATA1  input  8 each  byte to send for requester 0 / 1; valid while the matching REQ is high.
REQ-008 GNT0, GNT1  output  1 each  one-cycle acceptance pulse; DATA sampled on that edge.
REQ-009 TX  output  1  serial line, idle high.
REQ-010 BUSY  output  1  high in every state except IDLE.
REQ-011 SRC  output  1  index of the requester owning the current or most recent frame.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (only with PARITY_EN), and STOP; all outputs SHALL be registered.
REQ-013 In IDLE with any REQ high, the block SHALL grant exactly one requester, pulse its GNT for one cycle, latch its DATA into an 8-bit shift register, set SRC, and enter START on the same edge.
REQ-014 With both REQs high, the requester not served last SHALL win (round-robin); the last-served pointer SHALL reset to 1 so requester 0 wins the first contest.
REQ-015 With a single REQ high, that requester SHALL be granted regardless of the pointer.
REQ-016 BAUD_EN SHALL rise on the grant edge and fall on the edge leaving STOP.
REQ-017 A 4-bit tick counter SHALL increment on each TICK outside IDLE; when it reaches TICKS_PER_BIT-1 with TICK high, it SHALL clear and the current bit SHALL end.
REQ-018 TX SHALL be 0 in START, the shift-register LSB in DATA (LSB first, shifting right at each bit end), and 1 in STOP and IDLE.
REQ-019 A 3-bit bit counter SHALL leave DATA after the 8th bit ends.
REQ-020 A frame SHALL span exactly 10*TICKS_PER_BIT TICK pulses (11*TICKS_PER_BIT with PARITY_EN).
REQ-021 The edge leaving STOP SHALL enter IDLE.
  - IDLE SHALL last at least one cycle, so no GNT can coincide with frame end.
REQ-022 TICK SHALL be ignored in IDLE.
REQ-023 TICK coinciding with a grant SHALL NOT be counted.
REQ-024 REQ or DATA changes after a grant SHALL NOT affect the frame in progress.
REQ-025 A GNT SHALL never be issued outside IDLE.
REQ-026 GNT0 and GNT1 SHALL never be high together.

Reset
REQ-027 RESET high at a clock edge SHALL force the following, overriding all other inputs:
  - state IDLE;
  - TX=1, BUSY=0, BAUD_EN=0, GNT0=GNT1=0, SRC=0;
  - tick, bit and shift registers cleared;
  - round-robin pointer set to 1.
REQ-028 RESET mid-frame SHALL abort the frame with no GNT re-issued.
  - TX SHALL be 1 on the next edge.
  - An interrupted frame SHALL NOT resume after reset.

Configuration
REQ-029 With macro UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state between DATA and STOP.
  - PARITY SHALL last TICKS_PER_BIT ticks.
  - TX in PARITY SHALL be the even-parity bit (XOR of the 8 latched data bits).
REQ-030 Without UART_TX_PARITY_EN, PARITY SHALL not exist and DATA SHALL go directly to STOP.

Verification
REQ-031 REQ0=1, DATA0=8'h55, TICK every 4 CLK -> GNT0 one cycle; TX=0,1,0,1,0,1,0,1,0,1 each bit held 16 ticks (64 CLK); BUSY low after 160 ticks.
REQ-032 REQ0=REQ1=1 held continuously after reset -> grant order GNT0, GNT1, GNT0, GNT1; SRC toggles 0,1,0,1; at least one idle cycle between frames.
REQ-033 RESET pulsed during DATA bit 3 of an 8'hA3 frame -> next edge TX=1, BUSY=0, BAUD_EN=0; no GNT until REQ re-sampled in IDLE.
REQ-034 UART_TX_PARITY_EN defined, DATA1=8'h07 -> parity bit TX=1 for 16 ticks before the stop bit; frame is 176 ticks.
REQ-035 TICK held low for 1000 CLK mid-START -> TX stays 0 and BUSY stays 1; frame completes normally once TICK resumes.
REQ-036 TICKS_PER_BIT=8, DATA0=8'hFF -> start bit 8 ticks, data bits 8 ticks each, whole frame 80 ticks.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two-requester round-robin UART transmitter (8N1 framing).
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_tx_scheduler #(
  parameter int unsigned TICKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  output logic       BAUD_EN,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       TX,
  output logic       BUSY,
  output logic       SRC
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_q, last_d;
  logic        src_q, src_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        baud_q, baud_d;
  logic        bit_end;
  logic        pick1;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // Next-state logic; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    src_d   = src_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    pick1   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    bit_end = (state_q != ST_IDLE) && TICK && (tick_q == TICK_LAST);
    if ((state_q != ST_IDLE) && TICK) begin
      tick_d = bit_end ? '0 : tick_q + 4'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          // Requester 1 wins if it is alone, or if requester 0 was served last
          pick1   = REQ1 && (!REQ0 || !last_q);
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          shift_d = pick1 ? DATA1 : DATA0;
          src_d   = pick1;
          last_d  = pick1;
          tick_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^shift_d;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    baud_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b1;
      src_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      baud_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      src_q   <= src_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      baud_q  <= baud_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign BAUD_EN = baud_q;
  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign TX      = tx_q;
  assign BUSY    = busy_q;
  assign SRC     = src_q;

endmodule
